// File: rtl/i2c_target_mem.sv
// EEPROM-style I2C target model: 7-bit device address, 1-2 memory-address bytes,
// page-wrapped burst writes, sequential reads, write-protect, SCL stretching and a write-commit port.
module i2c_target_mem #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h50,
  parameter int         ADDR_BYTES     = 1,
  parameter int         MEM_DEPTH      = 256,
  parameter int         PAGE_SIZE      = 16,
  parameter int         STRETCH_CYCLES = 0,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_o,
  output logic                         sda_oe_o,
  output logic                         scl_oe_o,
  input  logic                         wp_i,
  output logic                         busy_o,
  output logic                         wr_strobe_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
  output logic [7:0]                   wr_data_o
);

  localparam int            AW           = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PAGE_MASK    = AW'(PAGE_SIZE - 1);
  localparam int            SCW          = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [SCW-1:0] STRETCH_LOAD = SCW'((STRETCH_CYCLES > 0) ? STRETCH_CYCLES - 1 : 0);
  localparam logic          LAST_IDX     = 1'(ADDR_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK, WR_DATA,
    WR_ACK, STRETCH, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  // Contents survive rst_i; only power-up sets every byte to erased (FF).
  logic [7:0] mem [MEM_DEPTH] = '{default: 8'hFF};

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [AW-1:0]  ptr_q, ptr_d, ptr_inc;
  logic [7:0]     addr_hi_q, addr_hi_d;
  logic           byte_idx_q, byte_idx_d;
  logic           phase_q, phase_d;
  logic           match_q, match_d;
  logic           ack_q, ack_d;
  logic [SCW-1:0] stretch_q, stretch_d;
  logic           sda_oe_d, scl_oe_d, busy_d, strobe_d;
  logic [AW-1:0]  wr_addr_d;
  logic [7:0]     wr_data_d;
  logic           mem_we;
  logic [7:0]     rx_byte, rd_cur, rd_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

  assign ptr_inc = ptr_q + 1'b1;
  assign rd_cur  = mem[ptr_q];
  assign rd_next = mem[ptr_inc];
  assign rx_byte = {shift_q[6:0], sda_s};

  // ACK states use phase: first SCL fall starts the ACK drive, second fall ends the ACK bit.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    addr_hi_d  = addr_hi_q;
    byte_idx_d = byte_idx_q;
    phase_d    = phase_q;
    match_d    = match_q;
    ack_d      = ack_q;
    stretch_d  = stretch_q;
    sda_oe_d   = sda_oe_o;
    scl_oe_d   = scl_oe_o;
    busy_d     = busy_o;
    strobe_d   = 1'b0;
    wr_addr_d  = wr_addr_o;
    wr_data_d  = wr_data_o;
    mem_we     = 1'b0;

    if (start_det) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = 3'd7;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      scl_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      phase_d  = 1'b0;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, WAIT_STOP: begin
        end

        DEV_ADDR, MEM_ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              bit_cnt_d = 3'd7;
              phase_d   = 1'b0;
              if (state_q == DEV_ADDR) begin
                match_d = (rx_byte[7:1] == SLAVE_ADDR);
                state_d = DEV_ACK;
              end else if (state_q == MEM_ADDR) begin
                state_d = MEM_ACK;
              end else begin
                ack_d   = ~wp_i;
                state_d = WR_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end

        DEV_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              if (match_q) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                phase_d  = 1'b1;
              end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = 3'd7;
              if (shift_q[0]) begin
                shift_d  = rd_cur;
                sda_oe_d = ~rd_cur[7];
                state_d  = RD_DATA;
              end else begin
                sda_oe_d   = 1'b0;
                byte_idx_d = 1'b0;
                state_d    = MEM_ADDR;
              end
            end
          end
        end

        MEM_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d   = 1'b0;
              sda_oe_d  = 1'b0;
              addr_hi_d = shift_q;
              if (byte_idx_q == LAST_IDX) begin
                ptr_d   = AW'({addr_hi_q, shift_q});
                state_d = WR_DATA;
              end else begin
                byte_idx_d = 1'b1;
                state_d    = MEM_ADDR;
              end
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = ack_q;
              phase_d  = 1'b1;
            end else begin
              phase_d  = 1'b0;
              sda_oe_d = 1'b0;
              state_d  = WR_DATA;
              if (ack_q) begin
                mem_we    = 1'b1;
                strobe_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = shift_q;
                ptr_d     = (ptr_q & ~PAGE_MASK) | (ptr_inc & PAGE_MASK);
                if (STRETCH_CYCLES > 0) begin
                  scl_oe_d  = 1'b1;
                  stretch_d = STRETCH_LOAD;
                  state_d   = STRETCH;
                end
              end
            end
          end
        end

        STRETCH: begin
          if (stretch_q == '0) begin
            scl_oe_d = 1'b0;
            state_d  = WR_DATA;
          end else begin
            stretch_d = stretch_q - 1'b1;
          end
        end

        // phase set means a fresh byte is loaded and its MSB goes out on the next fall.
        RD_DATA: begin
          if (scl_fall) begin
            if (phase_q) begin
              phase_d  = 1'b0;
              sda_oe_d = ~shift_q[7];
            end else if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q - 3'd1;
              sda_oe_d  = ~shift_q[6];
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d     = ptr_inc;
              shift_d   = rd_next;
              bit_cnt_d = 3'd7;
              phase_d   = 1'b1;
              state_d   = RD_DATA;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      addr_hi_q   <= 8'h00;
      byte_idx_q  <= 1'b0;
      phase_q     <= 1'b0;
      match_q     <= 1'b0;
      ack_q       <= 1'b0;
      stretch_q   <= '0;
      sda_o       <= 1'b1;
      sda_oe_o    <= 1'b0;
      scl_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      addr_hi_q   <= addr_hi_d;
      byte_idx_q  <= byte_idx_d;
      phase_q     <= phase_d;
      match_q     <= match_d;
      ack_q       <= ack_d;
      stretch_q   <= stretch_d;
      sda_o       <= 1'b0;
      sda_oe_o    <= sda_oe_d;
      scl_oe_o    <= scl_oe_d;
      busy_o      <= busy_d;
      wr_strobe_o <= strobe_d;
      wr_addr_o   <= wr_addr_d;
      wr_data_o   <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem[ptr_q] <= shift_q;
    end
  end

endmodule

// File: doc/i2c_target_mem.md
Name: i2c_target_mem

Overview:
- Parametrised I2C target (slave) model for simulation benches: EEPROM-like memory behind a 7-bit device address.
- Configurable memory-address byte count, depth and page-write wrap.
- Adds input synchronisation, write-protect, SCL clock stretching and a write-commit monitor port for scoreboards.
- Sits on the bench side of the I2C master peripheral, on the open-drain SDA/SCL nets.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit device address matched on the address byte.
ADDR_BYTES, 1, memory-address bytes after the device address (1 or 2); first received byte is MSB.
MEM_DEPTH, 256, memory bytes; power of two, at most 2^(8*ADDR_BYTES).
PAGE_SIZE, 16, write-burst wrap size; power of two, at most MEM_DEPTH.
STRETCH_CYCLES, 0, clk cycles SCL is held low after each write-data ACK; 0 disables stretching.
SYNC_STAGES, 2, flop stages on scl_i/sda_i before edge detection (minimum 2).

Ports:
clk_i  in  1  single clock; all logic posedge.
rst_i  in  1  synchronous, active-high reset.
scl_i  in  1  SCL line sample.
sda_i  in  1  SDA line sample.
sda_o  out  1  SDA drive value (only 0 used).
sda_oe_o  out  1  1 = drive SDA with sda_o.
scl_oe_o  out  1  1 = pull SCL low (stretch).
wp_i  in  1  write-protect; 1 = data bytes NACKed and not stored.
busy_o  out  1  transaction addressed to this target in progress.
wr_strobe_o  out  1  one-cycle pulse per committed byte.
wr_addr_o  out  $clog2(MEM_DEPTH)  address of committed byte, valid with strobe.
wr_data_o  out  8  committed byte, valid with strobe.

Behaviour:
- Reset values: sda_o=1, sda_oe_o=0, scl_oe_o=0, busy_o=0, wr_strobe_o=0, wr_addr_o=0, wr_data_o=0. State=IDLE, pointer=0, bit counter=7.
- Memory is initialised to 8'hFF at time zero. It is NOT cleared by rst_i.
- Sync and edge detection:
  - scl_i/sda_i pass through SYNC_STAGES flops.
  - Rise, fall, START (SDA fall while SCL high) and STOP (SDA rise while SCL high) are detected on synced values.
  - Pin-to-detect latency is SYNC_STAGES+1 clk.
- Bus-condition priority: START/STOP override every state, including STRETCH.
  - START or repeated START: go to DEV_ADDR, counter=7, release SDA, pointer retained (supports random read).
  - STOP: go to IDLE, busy_o=0. A partially received byte is discarded.
- States: IDLE, DEV_ADDR, DEV_ACK, MEM_ADDR, MEM_ACK, WR_DATA, WR_ACK, STRETCH, RD_DATA, RD_ACK, WAIT_STOP.
- DEV_ADDR: shifts sda on each SCL rise, MSB first. After 8 bits, go to DEV_ACK.
  - Match: assert busy_o, drive SDA low until the next SCL fall.
  - Mismatch: never drive SDA, go to IDLE on that fall.
- DEV_ACK, on SCL fall:
  - R/W=1: go to RD_DATA, load mem[pointer].
  - R/W=0: go to MEM_ADDR with byte index 0.
- MEM_ADDR/MEM_ACK: receive ADDR_BYTES bytes, ACKing each (regardless of wp_i). Assembled address mod MEM_DEPTH loads the pointer on the final ACK's SCL fall, then go to WR_DATA.
- WR_DATA: receive 8 bits, then go to WR_ACK.
  - wp_i=0 (sampled at the 8th SCL rise): ACK the byte. On the ACK's SCL fall, write mem[pointer], pulse wr_strobe_o with addr/data for exactly one cycle, then increment pointer with page wrap: low log2(PAGE_SIZE) bits wrap, upper bits held.
  - wp_i=1: NACK (SDA released), no write, no strobe, pointer unchanged.
  - On the ACK's SCL fall, go to STRETCH if STRETCH_CYCLES>0 and the byte was ACKed, else go to WR_DATA.
- STRETCH: scl_oe_o=1 for exactly STRETCH_CYCLES clk cycles starting the cycle after the fall, then release and go to WR_DATA.
- RD_DATA: drive shift MSB (sda_oe_o=1 only when bit=0). Shift on each SCL fall. After 8 bits, release SDA and go to RD_ACK.
- RD_ACK, on SCL rise:
  - SDA=0 (ACK): pointer+1 mod MEM_DEPTH (no page wrap on reads), load the next byte, go to RD_DATA.
  - SDA=1 (NACK): go to WAIT_STOP.
- WAIT_STOP: SDA released; wait for STOP or START.
- Outputs are registered; SDA changes 1 clk after the detected SCL fall.
- Reset mid-transaction: outputs take reset values on the next clk edge; IDLE; memory intact.

Test Plan:
- Write dev 0x50 (0xA0), mem 0x10, data 0xA5, 0x5A, STOP; then random read 0x10 of 2 bytes with master NACK on the last -> all ACKs low; reads 0xA5, 0x5A; two wr_strobe_o pulses (0x10/0xA5, 0x11/0x5A).
- PAGE_SIZE=16: write 3 bytes 0x01, 0x02, 0x03 from 0x1E -> mem[0x1E]=0x01, mem[0x1F]=0x02, mem[0x10]=0x03; mem[0x20] stays 0xFF.
- Address byte 0xA2 (dev 0x51) -> sda_oe_o never asserts, busy_o stays 0, subsequent bytes ignored until the next START.
- wp_i=1, write 0x77 to 0x05 -> dev/mem ACKed, data NACKed, no strobe, mem[0x05] stays 0xFF.
- ADDR_BYTES=2, MEM_DEPTH=1024, address bytes 0x03, 0xFF, sequential read of 2 bytes -> mem[0x3FF] then mem[0x000].
- STRETCH_CYCLES=8: write 1 byte -> scl_oe_o high exactly 8 cycles after the ACK fall. Then rst_i pulsed during RD_DATA -> sda_oe_o=0 next cycle, busy_o=0, memory contents unchanged.
